// File: rtl/apb_requester_if.sv
// Bundles the command, response and APB signals of apb_requester.
// master = the requester's view; slave = the command source / APB peripheral side.
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERROR;
  logic                  PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PSLVERROR, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PSLVERROR, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_requester.sv
// APB initiator: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
// Define APB_REQ_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES consecutive PREADY=0 cycles.
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              PCLK,
  input logic              PRESET,
  apb_requester_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  cmd_ready_s;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // A new command is only taken once the previous response has left.
  assign cmd_ready_s = (state_q == ST_IDLE) && !rsp_valid_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_REQ_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_s) begin
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          pwrite_d  = bus.cmd_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
`ifdef APB_REQ_TIMEOUT_EN
          tmo_cnt_d = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
          rsp_err_d   = bus.PSLVERROR;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end
`ifdef APB_REQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = ST_ACCESS;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transfer or pending response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      paddr_q     <= {ADDR_WIDTH{1'b0}};
      pwdata_q    <= {DATA_WIDTH{1'b0}};
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      rsp_err_q   <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      tmo_cnt_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_REQ_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: transfer-level model checked every cycle plus directed literals.
module tb_apb_requester;
  localparam int TMO = 4;
`ifdef APB_REQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  apb_requester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK   (pclk),
    .PRESET (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Simple APB peripheral: slv_ws wait states, data/error only on the completing cycle.
  int          slv_ws    = 0;
  int          slv_cnt   = 0;
  bit          slv_stuck = 1'b0;
  bit          slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  assign bus.PREADY    = bus.PSEL && bus.PENABLE && !slv_stuck && (slv_cnt == slv_ws);
  assign bus.PRDATA    = bus.PREADY ? slv_rdata : 32'hBAD0_BAD0;
  assign bus.PSLVERROR = bus.PREADY && slv_err;
  always @(posedge pclk) slv_cnt <= (bus.PENABLE && !bus.PREADY) ? slv_cnt + 1 : 0;

  // Transfer-level model: age = cycles since acceptance, wait = stalled ACCESS cycles.
  bit          started = 1'b0;
  bit          m_busy, m_rv, m_re, m_write;
  int          m_age, m_wait;
  logic [31:0] m_addr, m_wdata, m_rd;
  always @(posedge pclk) begin
    started <= 1'b1;
    if (rst) begin
      m_busy <= 1'b0; m_rv <= 1'b0; m_re <= 1'b0; m_write <= 1'b0;
      m_age <= 0; m_wait <= 0; m_addr <= 32'h0; m_wdata <= 32'h0; m_rd <= 32'h0;
    end else begin
      if (m_rv && bus.rsp_ready) m_rv <= 1'b0;
      if (!m_busy && !m_rv && bus.cmd_valid) begin
        m_busy <= 1'b1; m_age <= 1; m_wait <= 0;
        m_addr <= bus.cmd_addr; m_wdata <= bus.cmd_wdata; m_write <= bus.cmd_write;
      end else if (m_busy && m_age == 1) begin
        m_age <= 2;
      end else if (m_busy) begin
        if (bus.PREADY) begin
          m_busy <= 1'b0; m_rv <= 1'b1;
          m_rd <= m_write ? 32'h0 : bus.PRDATA;
          m_re <= bus.PSLVERROR;
        end else if (TMO_EN && (m_wait + 1 >= TMO)) begin
          m_busy <= 1'b0; m_rv <= 1'b1; m_rd <= 32'h0; m_re <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge pclk) begin
    if (started) begin
      chk("psel",      {31'h0, bus.PSEL},      {31'h0, m_busy});
      chk("penable",   {31'h0, bus.PENABLE},   {31'h0, (m_busy && m_age == 2)});
      chk("cmd_ready", {31'h0, bus.cmd_ready}, {31'h0, (!m_busy && !m_rv)});
      chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, m_rv});
      chk("paddr",     bus.PADDR,              m_addr);
      chk("pwdata",    bus.PWDATA,             m_wdata);
      chk("pwrite",    {31'h0, bus.PWRITE},    {31'h0, m_write});
      if (m_rv) begin
        chk("rsp_rdata", bus.rsp_rdata,          m_rd);
        chk("rsp_err",   {31'h0, bus.rsp_err},   {31'h0, m_re});
      end
    end
  end

  logic [31:0] setup_q[$];
  always @(negedge pclk) if (bus.PSEL && !bus.PENABLE) setup_q.push_back(bus.PADDR);

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    chk(name, {31'h0, ok}, 32'h1);
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge pclk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  logic [31:0] t4_addr [3] = '{32'h100, 32'h104, 32'h108};
  logic [31:0] t4_data [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  bit          t4_wr   [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int pen_cnt;
    int seen;
    bit got;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    @(negedge pclk);
    chk("reset_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    chk("reset_psel",      {31'h0, bus.PSEL},      32'h0);
    chk("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);

    // 1: write, zero wait states
    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge pclk);
    chk("t1_psel_n1",    {31'h0, bus.PSEL},    32'h1);
    chk("t1_penable_n1", {31'h0, bus.PENABLE}, 32'h0);
    @(negedge pclk);
    chk("t1_penable_n2", {31'h0, bus.PENABLE}, 32'h1);
    chk("t1_pwdata",     bus.PWDATA,           32'hDEAD_BEEF);
    @(negedge pclk);
    chk("t1_rsp_valid",  {31'h0, bus.rsp_valid}, 32'h1);
    chk("t1_rsp_err",    {31'h0, bus.rsp_err},   32'h0);
    chk("t1_rsp_rdata",  bus.rsp_rdata,          32'h0);
    chk("t1_psel_off",   {31'h0, bus.PSEL},      32'h0);
    consume();
    @(negedge pclk);
    chk("t1_rsp_cleared", {31'h0, bus.rsp_valid}, 32'h0);
    chk("t1_ready_again", {31'h0, bus.cmd_ready}, 32'h1);

    // 2: read with three wait states
    slv_ws = 3; slv_rdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h10, 32'h0);
    pen_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (bus.PENABLE) pen_cnt++;
    end
    chk("t2_penable_cycles", pen_cnt,       32'd4);
    chk("t2_rsp_valid_n6",   {31'h0, bus.rsp_valid}, 32'h1);
    chk("t2_rsp_rdata",      bus.rsp_rdata, 32'hCAFE_F00D);
    consume();

    // 3: slave error, response held while rsp_ready stays low
    slv_ws = 0; slv_err = 1'b1; slv_rdata = 32'h1234_5678;
    issue(1'b0, 32'h40, 32'h0);
    wait_rsp("t3_rsp_wait", 10);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rsp_err_hold",   {31'h0, bus.rsp_err},   32'h1);
      chk("t3_rsp_valid_hold", {31'h0, bus.rsp_valid}, 32'h1);
      chk("t3_cmd_ready_low",  {31'h0, bus.cmd_ready}, 32'h0);
      @(negedge pclk);
    end
    slv_err = 1'b0;
    consume();

    // 4: cmd_valid held across three commands, rsp_ready always high
    slv_rdata = 32'hA5A5_0001;
    bus.rsp_ready = 1'b1;
    setup_q.delete();
    for (int i = 0; i < 3; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_write = t4_wr[i];
      bus.cmd_addr = t4_addr[i]; bus.cmd_wdata = t4_data[i];
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge pclk);
        if (bus.cmd_ready) begin got = 1'b1; break; end
      end
      chk("t4_accept", {31'h0, got}, 32'h1);
      @(posedge pclk); #1;
    end
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge pclk);
    bus.rsp_ready = 1'b0;
    chk("t4_setup_count", setup_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < setup_q.size(); i++) chk("t4_order", setup_q[i], t4_addr[i]);

    // 5: reset pulse during a stalled ACCESS
    slv_stuck = 1'b1;
    issue(1'b0, 32'h200, 32'h0);
    repeat (3) @(negedge pclk);
    chk("t5_in_access", {31'h0, bus.PENABLE}, 32'h1);
    rst = 1'b1;
    @(posedge pclk); #1;
    rst = 1'b0;
    @(negedge pclk);
    chk("t5_psel",      {31'h0, bus.PSEL},      32'h0);
    chk("t5_penable",   {31'h0, bus.PENABLE},   32'h0);
    chk("t5_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("t5_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    slv_stuck = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) seen++;
    end
    chk("t5_no_response", seen, 32'd0);

`ifdef APB_REQ_TIMEOUT_EN
    // 6: PREADY stuck low aborts after TMO ACCESS cycles
    slv_stuck = 1'b1;
    issue(1'b0, 32'h300, 32'h0);
    pen_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (bus.PENABLE) pen_cnt++;
      if (bus.rsp_valid) begin got = 1'b1; break; end
    end
    chk("t6_rsp_seen",       {31'h0, got},           32'h1);
    chk("t6_access_cycles",  pen_cnt,                32'd4);
    chk("t6_rsp_err",        {31'h0, bus.rsp_err},   32'h1);
    chk("t6_rsp_rdata",      bus.rsp_rdata,          32'h0);
    slv_stuck = 1'b0;
    consume();
`endif

    repeat (3) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
